// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer and the mul/div unit.
// Holds the MDU state encoding, the hard-wired zero register index and the
// default MDU latency / countdown width used by both sides.
package hazard_ctrl_pkg;

  // MDU occupancy state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_t;

  // $zero never creates a load-use dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Issue-to-HI/LO-valid latency of the mul/div unit, and a countdown wide enough for it
  localparam int unsigned MDU_LAT_DEF = 32;
  localparam int unsigned CNT_W_DEF   = 6;

endpackage

// File: rtl/hazard_mdu_timer.sv
// MDU occupancy timer: tracks how long a mult/div stays in flight.
// A load in IDLE starts a countdown of MDU_LAT-1 busy cycles; HI/LO are
// readable in the first cycle the timer is back in IDLE. Loads while busy
// are ignored (the caller never issues while busy).
// Ports:
//   clk    in  core clock, rising edge
//   rst_n  in  synchronous reset, active-low
//   load   in  mult/div accepted this cycle
//   busy   out countdown active (registered state)
module hazard_mdu_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(1);

  mdu_state_t       state;
  mdu_state_t       state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // State and countdown registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state: load on issue, count down while busy, release after the last busy cycle
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_nxt = ST_BUSY;
          count_nxt = LOAD_VAL;
        end
      end
      ST_BUSY: begin
        count_nxt = count - CNT_W'(1);
        if (count == LAST_VAL) begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  assign busy = (state == ST_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core.
// Detects load-use and HI/LO hazards in ID, applies taken-branch flushes
// resolved in MEM, and tracks mult/div occupancy through hazard_mdu_timer.
// Stall/flush strobes are combinational from MDU state and inputs so they
// act in the same cycle.
// Optional build macro HAZARD_PERF_EN adds perf_stall_cnt / perf_flush_cnt.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_rs, id_rt               source fields of the ID instruction
//   id_uses_rs, id_uses_rt     ID instruction reads rs / rt
//   id_uses_hilo               ID instruction is mfhi/mflo
//   id_mdu_start               ID instruction is mult/div
//   ex_memread, ex_rt          load in EX and its destination
//   mem_br_taken               branch in MEM resolved taken
//   pc_write, ifid_write       PC / IF-ID update enables
//   ifid_flush, idex_flush,
//   exmem_flush                per-stage bubble strobes
//   mdu_busy                   MDU countdown active
//   mdu_issue                  mult/div accepted this cycle
//   perf_stall_cnt/flush_cnt   (HAZARD_PERF_EN) stall and flush cycle counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_uses_hilo,
  input  logic        id_mdu_start,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        mem_br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        mdu_busy,
  output logic        mdu_issue
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic load_use;
  logic hilo_haz;
  logic stall;

  // Load in EX whose destination feeds a source actually read in ID
  assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  // HI/LO readers and further mult/div wait for the running operation
  assign hilo_haz = mdu_busy && (id_uses_hilo || id_mdu_start);
  assign stall    = load_use || hilo_haz;

  // A flushed ID instruction cannot stall or start the MDU
  assign mdu_issue = id_mdu_start && !stall && !mem_br_taken;

  // Pipeline-register controls; taken branch overrides any stall
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (mem_br_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  hazard_mdu_timer #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mdu_issue),
    .busy  (mdu_busy)
  );

`ifdef HAZARD_PERF_EN
  // Free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && !mem_br_taken) begin
        perf_stall_cnt <= perf_stall_cnt + 32'(1);
      end
      if (mem_br_taken) begin
        perf_flush_cnt <= perf_flush_cnt + 32'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected per-cycle
// outputs from a cycle-count reference model; a negedge monitor compares.
module tb_hazard_ctrl;

  localparam int unsigned LAT = 4;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_uses_hilo;
  logic        id_mdu_start;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        mem_br_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        mdu_busy;
  logic        mdu_issue;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  hazard_ctrl #(
    .MDU_LAT (LAT),
    .CNT_W   (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_uses_hilo (id_uses_hilo),
    .id_mdu_start (id_mdu_start),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .mem_br_taken (mem_br_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .mdu_busy     (mdu_busy),
    .mdu_issue    (mdu_issue)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  outs;  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, mdu_busy, mdu_issue}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  // Reference model state: cycle index, first cycle the MDU is free again, event totals
  int          m_cyc;
  int          m_free_at;
  logic [31:0] m_sc;
  logic [31:0] m_fc;

  // Apply one cycle of inputs, predict outputs for it, advance to just after the edge
  task automatic step(input string tag, input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic uh, input logic ms,
                      input logic mr, input logic [4:0] ert, input logic br);
    logic lu, busy, st, issue;
    logic [6:0] o;
    exp_t e;
    rst_n = rst; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_uses_hilo = uh; id_mdu_start = ms; ex_memread = mr; ex_rt = ert; mem_br_taken = br;
    lu    = mr && (ert != 5'd0) && ((urs && rs == ert) || (urt && rt == ert));
    busy  = (m_cyc < m_free_at);
    st    = lu || (busy && (uh || ms));
    issue = ms && !st && !br;
    if (br)      o = 7'b1111100;
    else if (st) o = 7'b0001000;
    else         o = 7'b1100000;
    o[1] = busy;
    o[0] = issue;
    e.outs = o; e.sc = m_sc; e.fc = m_fc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (!rst) begin
      m_free_at = 0;
      m_sc = '0;
      m_fc = '0;
    end else begin
      if (issue) m_free_at = m_cyc + int'(LAT);
      if (st && !br) m_sc = m_sc + 32'(1);
      if (br) m_fc = m_fc + 32'(1);
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0);
  endtask

  // Monitor: every cycle presents a full set of outputs
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      logic [6:0] act;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, mdu_busy, mdu_issue};
      checks++;
      if (act !== e.outs) begin
        errors++;
        $display("FAIL %s strobes got=%b want=%b (pc,ifw,iff,idf,emf,busy,issue)", t, act, e.outs);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (perf_stall_cnt !== e.sc || perf_flush_cnt !== e.fc) begin
        errors++;
        $display("FAIL %s perf got=%0d/%0d want=%0d/%0d", t, perf_stall_cnt, perf_flush_cnt, e.sc, e.fc);
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_uses_hilo = 0; id_mdu_start = 0; ex_memread = 0; ex_rt = '0; mem_br_taken = 0;
    m_cyc = 0; m_free_at = 0; m_sc = '0; m_fc = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    idle("reset_state", 2);
    step("load_use", 1'b1, 5'd8, 5'd0, 1, 0, 0, 0, 1, 5'd8, 0);
    idle("load_use_release", 1);
    step("load_use_rt", 1'b1, 5'd0, 5'd9, 0, 1, 0, 0, 1, 5'd9, 0);
    step("load_zero_reg", 1'b1, 5'd0, 5'd0, 1, 0, 0, 0, 1, 5'd0, 0);
    step("load_unused_src", 1'b1, 5'd8, 5'd0, 0, 0, 0, 0, 1, 5'd8, 0);
    step("load_use_branch", 1'b1, 5'd8, 5'd0, 1, 0, 0, 0, 1, 5'd8, 1);
    step("branch_only", 1'b1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1);

    step("mdu_issue", 1'b1, 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
    idle("mdu_run", 5);

    step("mdu_issue2", 1'b1, 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
    for (int i = 0; i < 5; i++) step("hilo_wait", 1'b1, 5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0);

    step("mdu_issue3", 1'b1, 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
    step("mdu_branch", 1'b1, 5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 1);
    step("mdu_restart_blocked", 1'b1, 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
    idle("mdu_drain", 2);

    step("mdu_issue4", 1'b1, 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
    idle("mdu_count3", 1);
    step("reset_busy", 1'b0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0);
    idle("after_reset", 2);

    for (int n = 0; n < 2000; n++) begin
      logic r;
      r = ($urandom_range(63) != 0);
      step("random", r, 5'($urandom_range(3)), 5'($urandom_range(3)),
           1'($urandom), 1'($urandom), ($urandom_range(3) == 0), ($urandom_range(4) == 0),
           1'($urandom), 5'($urandom_range(3)), ($urandom_range(7) == 0));
    end
    idle("tail", 2);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
